// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester arbiter for the byte-banked data memory
module dmem_arbiter #(
  parameter int PRIO_MODE = 0,
  parameter int MAX_WAIT  = 3,
  parameter int MEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_we,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_we,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  dwe,
  input  logic [31:0] drdata
);

  localparam logic [31:0] LP_WORDS = MEM_WORDS[31:0];
  localparam logic [3:0]  LP_WAIT  = MAX_WAIT[3:0];

  logic        r_rr_last;
  logic [3:0]  r_starve;
  logic        r_acc_valid;
  logic        r_acc_owner;
  logic [29:0] r_acc_idx;
  logic [31:0] r_acc_wdata;
  logic [3:0]  r_acc_we;
  logic        r_acc_oor;
  logic        r_m0_rvalid;
  logic [31:0] r_m0_rdata;
  logic        r_m0_err;
  logic        r_m1_rvalid;
  logic [31:0] r_m1_rdata;
  logic        r_m1_err;

  logic        w_m0_gnt;
  logic        w_m1_gnt;
  logic [29:0] w_sel_idx;
  logic [31:0] w_sel_wdata;
  logic [3:0]  w_sel_we;
  logic        w_sel_oor;
  logic [31:0] w_resp_data;
  logic        w_unused_bits;

  assign w_unused_bits = ^{m0_addr[1:0], m1_addr[1:0]};

  always_comb begin
    w_m0_gnt = 1'b0;
    w_m1_gnt = 1'b0;
    if (PRIO_MODE == 0) begin
      // r_rr_last=1 means m1 was granted last, so m0 wins a tie
      if (m0_req && m1_req) begin
        w_m0_gnt = r_rr_last;
        w_m1_gnt = !r_rr_last;
      end else begin
        w_m0_gnt = m0_req;
        w_m1_gnt = m1_req;
      end
    end else begin
      w_m1_gnt = m1_req && (!m0_req || (r_starve == LP_WAIT));
      w_m0_gnt = m0_req && !w_m1_gnt;
    end
  end

  assign w_sel_idx   = w_m1_gnt ? m1_addr[31:2] : m0_addr[31:2];
  assign w_sel_wdata = w_m1_gnt ? m1_wdata : m0_wdata;
  assign w_sel_we    = w_m1_gnt ? m1_we : m0_we;
  assign w_sel_oor   = ({2'b00, w_sel_idx} >= LP_WORDS);

  // Writes and out-of-range accesses answer with zero
  assign w_resp_data = (r_acc_we == 4'b0000 && !r_acc_oor) ? drdata : 32'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_last   <= 1'b1;
      r_starve    <= 4'd0;
      r_acc_valid <= 1'b0;
      r_acc_owner <= 1'b0;
      r_acc_idx   <= 30'd0;
      r_acc_wdata <= 32'h0;
      r_acc_we    <= 4'b0000;
      r_acc_oor   <= 1'b0;
      r_m0_rvalid <= 1'b0;
      r_m0_rdata  <= 32'h0;
      r_m0_err    <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m1_rdata  <= 32'h0;
      r_m1_err    <= 1'b0;
    end else begin
      if (w_m0_gnt || w_m1_gnt) begin
        r_rr_last <= w_m1_gnt;
      end
      if (w_m1_gnt || !m1_req) begin
        r_starve <= 4'd0;
      end else if (w_m0_gnt && r_starve != 4'hF) begin
        r_starve <= r_starve + 4'd1;
      end

      r_acc_valid <= w_m0_gnt || w_m1_gnt;
      if (w_m0_gnt || w_m1_gnt) begin
        r_acc_owner <= w_m1_gnt;
        r_acc_idx   <= w_sel_idx;
        r_acc_wdata <= w_sel_wdata;
        r_acc_we    <= w_sel_we;
        r_acc_oor   <= w_sel_oor;
      end

      r_m0_rvalid <= r_acc_valid && !r_acc_owner;
      r_m0_rdata  <= (r_acc_valid && !r_acc_owner) ? w_resp_data : 32'h0;
      r_m0_err    <= r_acc_valid && !r_acc_owner && r_acc_oor;
      r_m1_rvalid <= r_acc_valid && r_acc_owner;
      r_m1_rdata  <= (r_acc_valid && r_acc_owner) ? w_resp_data : 32'h0;
      r_m1_err    <= r_acc_valid && r_acc_owner && r_acc_oor;
    end
  end

  assign m0_gnt    = w_m0_gnt;
  assign m1_gnt    = w_m1_gnt;
  assign m0_rvalid = r_m0_rvalid;
  assign m0_rdata  = r_m0_rdata;
  assign m0_err    = r_m0_err;
  assign m1_rvalid = r_m1_rvalid;
  assign m1_rdata  = r_m1_rdata;
  assign m1_err    = r_m1_err;
  assign daddr     = {r_acc_idx, 2'b00};
  assign dwdata    = r_acc_wdata;
  assign dwe       = (r_acc_valid && !r_acc_oor) ? r_acc_we : 4'b0000;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed bench for dmem_arbiter (round-robin and fixed-priority instances)
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_we, m1_we;

  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata, daddr, dwdata, drdata;
  logic [3:0]  dwe;

  logic        f_m0_gnt, f_m0_rvalid, f_m0_err, f_m1_gnt, f_m1_rvalid, f_m1_err;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_daddr, f_dwdata;
  logic [31:0] f_drdata;
  logic [3:0]  f_dwe;

  logic [31:0] mem [0:4095];
  int n_pass;
  int n_total;

  dmem_arbiter #(.PRIO_MODE(0), .MAX_WAIT(3), .MEM_WORDS(4096)) u_rr (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata)
  );

  dmem_arbiter #(.PRIO_MODE(1), .MAX_WAIT(3), .MEM_WORDS(4096)) u_fx (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
    .m0_gnt(f_m0_gnt), .m0_rvalid(f_m0_rvalid), .m0_rdata(f_m0_rdata), .m0_err(f_m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
    .m1_gnt(f_m1_gnt), .m1_rvalid(f_m1_rvalid), .m1_rdata(f_m1_rdata), .m1_err(f_m1_err),
    .daddr(f_daddr), .dwdata(f_dwdata), .dwe(f_dwe), .drdata(f_drdata)
  );

  assign f_drdata = 32'h0;
  assign drdata   = mem[daddr[13:2]];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (dwe[b]) mem[daddr[13:2]][8*b +: 8] <= dwdata[8*b +: 8];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    for (int k = 0; k < 4096; k++) mem[k] = 32'h0;
    reset = 1'b0;
    m0_req = 0; m0_addr = 0; m0_wdata = 0; m0_we = 0;
    m1_req = 0; m1_addr = 0; m1_wdata = 0; m1_we = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #4;
    chk("rst_dwe", {28'h0, dwe}, 32'h0);
    chk("rst_daddr", daddr, 32'h0);
    chk("rst_dwdata", dwdata, 32'h0);
    chk("rst_m0_rvalid", {31'h0, m0_rvalid}, 32'h0);
    chk("rst_m1_rvalid", {31'h0, m1_rvalid}, 32'h0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);

    // m0 write then m1 read of the same word on the next cycle
    @(posedge clk); #1;
    m0_req = 1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF; m0_we = 4'hF;
    #4;
    chk("t1_m0_gnt", {31'h0, m0_gnt}, 32'h1);
    chk("t1_m1_gnt", {31'h0, m1_gnt}, 32'h0);
    @(posedge clk); #1;
    m0_req = 0;
    m1_req = 1; m1_addr = 32'h10; m1_wdata = 32'h0; m1_we = 4'h0;
    #4;
    chk("t1_m1_gnt_c1", {31'h0, m1_gnt}, 32'h1);
    chk("t1_dwe", {28'h0, dwe}, 32'hF);
    chk("t1_daddr", daddr, 32'h10);
    chk("t1_dwdata", dwdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    m1_req = 0;
    #4;
    chk("t1_m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
    chk("t1_m0_rdata", m0_rdata, 32'h0);
    chk("t1_m0_err", {31'h0, m0_err}, 32'h0);
    chk("t1_m1_rvalid_early", {31'h0, m1_rvalid}, 32'h0);
    @(posedge clk); #5;
    chk("t1_m1_rvalid", {31'h0, m1_rvalid}, 32'h1);
    chk("t1_m1_rdata", m1_rdata, 32'hDEADBEEF);
    chk("t1_m1_err", {31'h0, m1_err}, 32'h0);
    chk("t1_m0_rvalid_low", {31'h0, m0_rvalid}, 32'h0);

    // both requesters held high for 8 cycles: RR alternates, fixed mode guards m1
    @(posedge clk); #1;
    m0_req = 1; m0_addr = 32'h10; m0_we = 4'h0;
    m1_req = 1; m1_addr = 32'h10; m1_we = 4'h0;
    for (int i = 0; i < 10; i++) begin
      #4;
      if (i < 8) begin
        chk($sformatf("rr_m0_gnt_%0d", i), {31'h0, m0_gnt}, (i % 2 == 0) ? 32'h1 : 32'h0);
        chk($sformatf("rr_m1_gnt_%0d", i), {31'h0, m1_gnt}, (i % 2 == 1) ? 32'h1 : 32'h0);
        chk($sformatf("fx_m1_gnt_%0d", i), {31'h0, f_m1_gnt}, (i == 3 || i == 7) ? 32'h1 : 32'h0);
        chk($sformatf("fx_m0_gnt_%0d", i), {31'h0, f_m0_gnt}, (i == 3 || i == 7) ? 32'h0 : 32'h1);
      end
      if (i >= 2) begin
        chk($sformatf("rr_m0_rvalid_%0d", i), {31'h0, m0_rvalid}, (i % 2 == 0) ? 32'h1 : 32'h0);
        chk($sformatf("rr_m1_rvalid_%0d", i), {31'h0, m1_rvalid}, (i % 2 == 1) ? 32'h1 : 32'h0);
      end
      if (i == 3) chk("rr_m1_rdata", m1_rdata, 32'hDEADBEEF);
      @(posedge clk); #1;
      if (i == 7) begin
        m0_req = 0;
        m1_req = 0;
      end
    end

    // partial-lane write into word 0x20
    m0_req = 1; m0_addr = 32'h20; m0_wdata = 32'h11223344; m0_we = 4'hF;
    #4;
    chk("t4_m0_gnt", {31'h0, m0_gnt}, 32'h1);
    @(posedge clk); #1;
    m0_req = 0;
    m1_req = 1; m1_addr = 32'h20; m1_wdata = 32'h0000AB00; m1_we = 4'b0010;
    #4;
    chk("t4_m1_gnt", {31'h0, m1_gnt}, 32'h1);
    @(posedge clk); #1;
    m1_req = 0;
    m0_req = 1; m0_addr = 32'h20; m0_wdata = 32'h0; m0_we = 4'h0;
    #4;
    chk("t4_dwe_lane", {28'h0, dwe}, 32'h2);
    @(posedge clk); #1;
    m0_req = 0;
    #4;
    chk("t4_m1_rdata_wr", m1_rdata, 32'h0);
    @(posedge clk); #5;
    chk("t4_m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
    chk("t4_m0_rdata", m0_rdata, 32'h1122AB44);
    chk("t4_mem", mem[8], 32'h1122AB44);

    // out-of-range write must not alias onto word 0
    @(posedge clk); #1;
    m1_req = 1; m1_addr = 32'h0; m1_wdata = 32'hCAFEF00D; m1_we = 4'hF;
    @(posedge clk); #1;
    m1_req = 0;
    m0_req = 1; m0_addr = 32'h4000; m0_wdata = 32'h12345678; m0_we = 4'hF;
    #4;
    chk("t5_m0_gnt", {31'h0, m0_gnt}, 32'h1);
    @(posedge clk); #1;
    m0_req = 0;
    #4;
    chk("t5_dwe", {28'h0, dwe}, 32'h0);
    chk("t5_daddr", daddr, 32'h4000);
    @(posedge clk); #5;
    chk("t5_m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
    chk("t5_m0_err", {31'h0, m0_err}, 32'h1);
    chk("t5_m0_rdata", m0_rdata, 32'h0);
    chk("t5_mem0", mem[0], 32'hCAFEF00D);

    // reset asserted while a write is staged
    @(posedge clk); #1;
    m0_req = 1; m0_addr = 32'h30; m0_wdata = 32'h55AA55AA; m0_we = 4'hF;
    @(posedge clk); #1;
    m0_wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    m0_req = 0;
    #1;
    chk("t6_dwe_staged", {28'h0, dwe}, 32'hF);
    #1 reset = 1'b0;
    #1;
    chk("t6_dwe_rst", {28'h0, dwe}, 32'h0);
    chk("t6_rvalid_rst", {31'h0, m0_rvalid}, 32'h0);
    @(posedge clk); #1;
    chk("t6_mem_old", mem[12], 32'h55AA55AA);
    chk("t6_rvalid_hold", {31'h0, m0_rvalid}, 32'h0);
    reset = 1'b1;
    @(posedge clk); #5;
    chk("t6_m0_rvalid_after", {31'h0, m0_rvalid}, 32'h0);
    chk("t6_m1_rvalid_after", {31'h0, m1_rvalid}, 32'h0);
    chk("t6_mem_final", mem[12], 32'h55AA55AA);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
